execute_cycle: RTL and testbench

Execute stage of the 5-stage RV32I pipeline. It resolves forwarded operands, runs the ALU, and evaluates branch/jump redirection. It registers all memory-stage controls and data into the E/M pipeline register, which drives the memory stage directly. It also returns the branch decision and target combinationally to fetch.

---
 rtl/execute_cycle_pkg.sv | 63 ++++++
 rtl/execute_cycle_alu.sv | 32 +++
 rtl/execute_cycle.sv | 93 +++++++++
 tb/tb_execute_cycle.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_cycle_pkg.sv
// Shared encodings and the E/M pipeline payload for the RV32I execute stage.
package execute_cycle_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned FWD_W      = 2;
  localparam int unsigned RES_SRC_W  = 2;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned SHAMT_W    = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_LUI  = 4'd10;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  localparam logic [RES_SRC_W-1:0] RES_ALU = 2'b00;
  localparam logic [RES_SRC_W-1:0] RES_MEM = 2'b01;
  localparam logic [RES_SRC_W-1:0] RES_PC4 = 2'b10;

  localparam logic [FUNCT3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_BNE = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_BLT = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_BGE = 3'b101;

  typedef struct packed {
    logic                   regWrite;
    logic [RES_SRC_W-1:0]   resultSrc;
    logic                   memWrite;
    logic [XLEN-1:0]        aluResult;
    logic [XLEN-1:0]        writeData;
    logic [XLEN-1:0]        pcPlus4;
    logic [REG_ADDR_W-1:0]  rd;
  } emRegT;

  // Branch condition on forwarded operands; unsupported funct3 never branches.
  function automatic logic branchCond(input logic [FUNCT3_W-1:0] funct3,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    logic cond;
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = (a == b);
      F3_BNE:  cond = (a != b);
      F3_BLT:  cond = ($signed(a) < $signed(b));
      F3_BGE:  cond = ($signed(a) >= $signed(b));
      default: cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational RV32I ALU; overflow discarded, undefined opcodes yield zero.
module execute_cycle_alu
  import execute_cycle_pkg::*;
(
  input  logic [ALU_CTRL_W-1:0] aluControl,
  input  logic [XLEN-1:0]       srcA,
  input  logic [XLEN-1:0]       srcB,
  output logic [XLEN-1:0]       aluResult_c
);

  logic [SHAMT_W-1:0] shamt;

  always_comb begin
    shamt       = srcB[SHAMT_W-1:0];
    aluResult_c = '0;
    case (aluControl)
      ALU_ADD:  aluResult_c = srcA + srcB;
      ALU_SUB:  aluResult_c = srcA - srcB;
      ALU_AND:  aluResult_c = srcA & srcB;
      ALU_OR:   aluResult_c = srcA | srcB;
      ALU_XOR:  aluResult_c = srcA ^ srcB;
      ALU_SLT:  aluResult_c = XLEN'($signed(srcA) < $signed(srcB));
      ALU_SLTU: aluResult_c = XLEN'(srcA < srcB);
      ALU_SLL:  aluResult_c = srcA << shamt;
      ALU_SRL:  aluResult_c = srcA >> shamt;
      ALU_SRA:  aluResult_c = XLEN'($signed(srcA) >>> shamt);
      ALU_LUI:  aluResult_c = srcB;
      default:  aluResult_c = '0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and E/M register.
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic [RES_SRC_W-1:0]  ResultSrcE,
  input  logic                  MemWriteE,
  input  logic                  JumpE,
  input  logic                  BranchE,
  input  logic [FUNCT3_W-1:0]   Funct3E,
  input  logic [ALU_CTRL_W-1:0] ALUControlE,
  input  logic                  ALUSrcE,
  input  logic [XLEN-1:0]       RD1E,
  input  logic [XLEN-1:0]       RD2E,
  input  logic [XLEN-1:0]       ImmExtE,
  input  logic [XLEN-1:0]       PCE,
  input  logic [XLEN-1:0]       PCPlus4E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [FWD_W-1:0]      ForwardAE,
  input  logic [FWD_W-1:0]      ForwardBE,
  input  logic [XLEN-1:0]       ResultW,
  output logic                  PCSrcE,
  output logic [XLEN-1:0]       PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [RES_SRC_W-1:0]  ResultSrcM,
  output logic [XLEN-1:0]       ALUResultM,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [XLEN-1:0]       PCPlus4M,
  output logic [REG_ADDR_W-1:0] RdM
);

  emRegT           emQ;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] fwdB;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] aluResult;

  // Forwarding muxes; the MEM path taps our own registered ALU result.
  always_comb begin
    srcA = RD1E;
    fwdB = RD2E;
    case (ForwardAE)
      FWD_WB:  srcA = ResultW;
      FWD_MEM: srcA = emQ.aluResult;
      default: srcA = RD1E;
    endcase
    case (ForwardBE)
      FWD_WB:  fwdB = ResultW;
      FWD_MEM: fwdB = emQ.aluResult;
      default: fwdB = RD2E;
    endcase
    srcB = ALUSrcE ? ImmExtE : fwdB;
  end

  execute_cycle_alu uAlu (
    .aluControl  (ALUControlE),
    .srcA        (srcA),
    .srcB        (srcB),
    .aluResult_c (aluResult)
  );

  // Redirect to fetch stays combinational, even while the E/M register is in reset.
  always_comb begin
    PCTargetE = PCE + ImmExtE;
    PCSrcE    = JumpE | (BranchE & branchCond(Funct3E, srcA, fwdB));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      emQ <= '0;
    end else begin
      emQ.regWrite  <= RegWriteE;
      emQ.resultSrc <= ResultSrcE;
      emQ.memWrite  <= MemWriteE;
      emQ.aluResult <= aluResult;
      emQ.writeData <= fwdB;
      emQ.pcPlus4   <= PCPlus4E;
      emQ.rd        <= RdE;
    end
  end

  assign RegWriteM  = emQ.regWrite;
  assign ResultSrcM = emQ.resultSrc;
  assign MemWriteM  = emQ.memWrite;
  assign ALUResultM = emQ.aluResult;
  assign WriteDataM = emQ.writeData;
  assign PCPlus4M   = emQ.pcPlus4;
  assign RdM        = emQ.rd;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed cases plus randomized traffic against a behavioural model.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  Funct3E;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic        PCSrcE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;

  int checks = 0;
  int failures = 0;

  // Model of the M-stage state
  logic        mRegWrite, mMemWrite;
  logic [1:0]  mResultSrc;
  logic [31:0] mAlu, mWd, mPc4;
  logic [4:0]  mRd;

  execute_cycle dut (
    .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .Funct3E(Funct3E),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return ResultW;
    if (sel == 2'b10) return mAlu;
    return rf;
  endfunction

  function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int    sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      4'd0:  return 32'((longint'(a) + longint'(b)) % (64'd1 << 32));
      4'd1:  return 32'((longint'(a) - longint'(b) + (64'd1 << 32)) % (64'd1 << 32));
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd7:  return 32'(longint'(a) * (64'd1 << sh));
      4'd8:  return 32'(longint'(a) / (64'd1 << sh));
      4'd9:  return 32'((sa >= 0) ? (sa / (64'sd1 <<< sh)) : -((-sa + (64'sd1 <<< sh) - 1) / (64'sd1 <<< sh)));
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic takenRef(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (JumpE) return 1'b1;
    if (!BranchE) return 1'b0;
    case (Funct3E)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return sa < sb;
      3'b101: return sa >= sb;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    mRegWrite = 0; mMemWrite = 0; mResultSrc = 0;
    mAlu = 0; mWd = 0; mPc4 = 0; mRd = 0;
  endtask

  task automatic defaults();
    RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
    ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0; Funct3E = 0; ALUControlE = 0;
    RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; ResultW = 0; RdE = 0;
  endtask

  task automatic checkRegs();
    chk("RegWriteM", 32'(RegWriteM), 32'(mRegWrite));
    chk("MemWriteM", 32'(MemWriteM), 32'(mMemWrite));
    chk("ResultSrcM", 32'(ResultSrcM), 32'(mResultSrc));
    chk("ALUResultM", ALUResultM, mAlu);
    chk("WriteDataM", WriteDataM, mWd);
    chk("PCPlus4M", PCPlus4M, mPc4);
    chk("RdM", 32'(RdM), 32'(mRd));
  endtask

  // Inputs are already driven: check redirect, clock once, check the E/M register.
  task automatic step();
    logic [31:0] a, fb, b, nAlu;
    #1;
    a  = pick(ForwardAE, RD1E);
    fb = pick(ForwardBE, RD2E);
    b  = ALUSrcE ? ImmExtE : fb;
    chk("PCSrcE", 32'(PCSrcE), 32'(takenRef(a, fb)));
    chk("PCTargetE", PCTargetE, 32'((longint'(PCE) + longint'(ImmExtE)) % (64'd1 << 32)));
    nAlu = aluRef(ALUControlE, a, b);
    @(posedge clk);
    if (rst) begin
      mRegWrite = RegWriteE; mMemWrite = MemWriteE; mResultSrc = ResultSrcE;
      mAlu = nAlu; mWd = fb; mPc4 = PCPlus4E; mRd = RdE;
    end
    #1;
    checkRegs();
  endtask

  initial begin
    defaults();
    modelReset();
    rst = 0;
    // Reset holds registers at zero despite live inputs
    RegWriteE = 1; RdE = 5; RD1E = 32'h55;
    step();
    chk("lit_rst_rd", 32'(RdM), 32'd0);
    chk("lit_rst_alu", ALUResultM, 32'd0);
    rst = 1;
    step();
    chk("lit_rel_regwrite", 32'(RegWriteM), 32'd1);
    chk("lit_rel_rd", 32'(RdM), 32'd5);

    // ALU with immediate and register operands
    defaults(); RD1E = 7; ImmExtE = 32'hFFFF_FFFD; ALUSrcE = 1; ALUControlE = 4'd0;
    step();
    chk("lit_add_imm", ALUResultM, 32'd4);
    ALUSrcE = 0; RD2E = 9; ALUControlE = 4'd1;
    step();
    chk("lit_sub", ALUResultM, 32'hFFFF_FFFE);
    RD1E = 32'hFFFF_FFFF; RD2E = 1; ALUControlE = 4'd5;
    step();
    chk("lit_slt", ALUResultM, 32'd1);
    ALUControlE = 4'd6;
    step();
    chk("lit_sltu", ALUResultM, 32'd0);
    RD1E = 32'h8000_0000; RD2E = 4; ALUControlE = 4'd9;
    step();
    chk("lit_sra", ALUResultM, 32'hF800_0000);

    // Forwarding from M and W simultaneously, then into a store
    defaults(); RD1E = 32'h10; ALUControlE = 4'd0;
    step();
    RD1E = 32'hAAAA; RD2E = 32'hBBBB; ResultW = 32'h20; ForwardAE = 2'b10; ForwardBE = 2'b01;
    step();
    chk("lit_fwd_add", ALUResultM, 32'h30);
    defaults(); RD1E = 32'h10;
    step();
    MemWriteE = 1; RD1E = 32'h100; ImmExtE = 8; ALUSrcE = 1; RD2E = 32'hDEAD; ForwardBE = 2'b10;
    step();
    chk("lit_store_wd", WriteDataM, 32'h10);

    // Branch conditions on forwarded operands, immediate selected for the ALU
    defaults(); BranchE = 1; Funct3E = 3'b000; RD1E = 5; RD2E = 5; ALUSrcE = 1;
    ImmExtE = 32'h40; PCE = 32'h100;
    #1;
    chk("lit_beq", 32'(PCSrcE), 32'd1);
    chk("lit_beq_tgt", PCTargetE, 32'h140);
    step();
    Funct3E = 3'b001;
    #1;
    chk("lit_bne", 32'(PCSrcE), 32'd0);
    step();
    Funct3E = 3'b100; RD1E = 32'hFFFF_FFFF; RD2E = 1;
    #1;
    chk("lit_blt", 32'(PCSrcE), 32'd1);
    step();

    // Jump with target wrap-around
    defaults(); JumpE = 1; PCE = 32'hFFFF_FFF8; ImmExtE = 32'h10; ResultSrcE = 2'b10;
    PCPlus4E = 32'hFFFF_FFFC; RegWriteE = 1; RdE = 1;
    #1;
    chk("lit_jal_tgt", PCTargetE, 32'h8);
    chk("lit_jal_taken", 32'(PCSrcE), 32'd1);
    step();
    chk("lit_jal_ressrc", 32'(ResultSrcM), 32'd2);
    chk("lit_jal_pc4", PCPlus4M, 32'hFFFF_FFFC);

    // Asynchronous reset drops an in-flight store before the next edge
    defaults(); MemWriteE = 1; RD2E = 32'h77;
    step();
    chk("lit_store_before_rst", 32'(MemWriteM), 32'd1);
    rst = 0;
    #2;
    chk("lit_async_memwrite", 32'(MemWriteM), 32'd0);
    chk("lit_async_wd", WriteDataM, 32'd0);
    modelReset();
    JumpE = 1; PCE = 32'h20; ImmExtE = 32'h4;
    step();
    chk("lit_rst_comb_tgt", PCTargetE, 32'h24);
    rst = 1;
    defaults();
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      RegWriteE   = 1'($urandom);
      MemWriteE   = 1'($urandom);
      JumpE       = ($urandom_range(0, 7) == 0);
      BranchE     = 1'($urandom);
      ALUSrcE     = 1'($urandom);
      ResultSrcE  = 2'($urandom);
      ForwardAE   = 2'($urandom);
      ForwardBE   = 2'($urandom);
      Funct3E     = 3'($urandom);
      ALUControlE = 4'($urandom_range(0, 15));
      RD1E        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      RD2E        = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
      ImmExtE     = $urandom;
      PCE         = $urandom;
      PCPlus4E    = PCE + 32'd4;
      ResultW     = $urandom;
      RdE         = 5'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
